// File: rtl/rice_encode_if.sv
// Sample-in / bitstream-out handshake bundle for the Rice residual encoder.
// Master drives samples and consumes bits; slave is the encoder.
interface rice_encode_if;
    logic        iValid;
    logic [15:0] iMSB;
    logic [15:0] iLSB;
    logic [3:0]  iRiceParam;
    logic        oReady;
    logic        iEn;
    logic        oData;
    logic        oValid;
    logic        oFrameDone;

    modport master (
        output iValid, iMSB, iLSB, iRiceParam, iEn,
        input  oReady, oData, oValid, oFrameDone
    );

    modport slave (
        input  iValid, iMSB, iLSB, iRiceParam, iEn,
        output oReady, oData, oValid, oFrameDone
    );
endinterface

// File: rtl/rice_encode.sv
// Serial partitioned Rice residual encoder, one stream bit per enabled cycle.
// Optional RICE_BITCOUNT_EN adds oBitCount, the consumed-bit count per frame.
module rice_encode #(
    parameter int MAX_PART_ORDER = 8
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [15:0] iBlockSize,
    input  logic [3:0]  iPredictorOrder,
    input  logic [3:0]  iPartitionOrder,
    rice_encode_if.slave bus
`ifdef RICE_BITCOUNT_EN
    ,
    output logic [31:0] oBitCount
`endif
);
    localparam int PCW = MAX_PART_ORDER + 1;

    typedef enum logic [1:0] {IDLE, PARAM, UNARY, REMAINDER} state_t;

    state_t state, stateNext;

    logic [15:0]    cfgBlockSize;
    logic [3:0]     cfgPredOrder;
    logic [3:0]     cfgPartOrder;
    logic [15:0]    msbReg;
    logic [15:0]    lsbReg;
    logic [15:0]    bitCnt;
    logic [3:0]     param;
    logic [15:0]    sampleCount;
    logic [PCW-1:0] partCount;
    logic           frameDone;

    logic           accept;
    logic           adv;
    logic           unaryLast;
    logic           sampleDone;
    logic           dataBit;
    logic [15:0]    shifted;
    logic [15:0]    nLast;
    logic [PCW-1:0] partMax;
    logic           sampleLast;
    logic           partLast;

    assign accept    = bus.iValid && (state == IDLE);
    assign adv       = (state != IDLE) && bus.iEn;
    assign unaryLast = (bitCnt == msbReg);
    assign shifted   = cfgBlockSize >> cfgPartOrder;
    assign partMax   = (PCW'(1) << cfgPartOrder) - PCW'(1);
    assign sampleLast = (sampleCount == nLast);
    assign partLast   = (partCount == partMax);

    // Warm-up samples only shorten the first partition.
    always_comb begin
        nLast = shifted - 16'd1;
        if (cfgPartOrder == 4'd0)
            nLast = cfgBlockSize - {12'd0, cfgPredOrder} - 16'd1;
        else if (partCount == '0)
            nLast = shifted - {12'd0, cfgPredOrder} - 16'd1;
    end

    always_comb begin
        sampleDone = 1'b0;
        if (adv) begin
            if (state == UNARY && unaryLast && param == 4'd0)
                sampleDone = 1'b1;
            if (state == REMAINDER && bitCnt == 16'd0)
                sampleDone = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        dataBit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept)
                    stateNext = (sampleCount == 16'd0) ? PARAM : UNARY;
            end
            PARAM: begin
                dataBit = param[bitCnt[1:0]];
                if (adv && bitCnt == 16'd0)
                    stateNext = UNARY;
            end
            UNARY: begin
                dataBit = unaryLast;
                if (adv && unaryLast)
                    stateNext = (param != 4'd0) ? REMAINDER : IDLE;
            end
            REMAINDER: begin
                dataBit = lsbReg[bitCnt[3:0]];
                if (adv && bitCnt == 16'd0)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cfgBlockSize <= iBlockSize;
            cfgPredOrder <= iPredictorOrder;
            cfgPartOrder <= iPartitionOrder;
            msbReg       <= '0;
            lsbReg       <= '0;
            bitCnt       <= '0;
            param        <= '0;
            sampleCount  <= '0;
            partCount    <= '0;
            frameDone    <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (frameDone) begin
                cfgBlockSize <= iBlockSize;
                cfgPredOrder <= iPredictorOrder;
                cfgPartOrder <= iPartitionOrder;
            end
            if (accept) begin
                msbReg <= bus.iMSB;
                lsbReg <= bus.iLSB;
                if (sampleCount == 16'd0) begin
                    param  <= bus.iRiceParam;
                    bitCnt <= 16'd3;
                end else begin
                    bitCnt <= 16'd0;
                end
            end
            if (adv) begin
                unique case (state)
                    PARAM: begin
                        if (bitCnt != 16'd0)
                            bitCnt <= bitCnt - 16'd1;
                    end
                    UNARY: begin
                        if (unaryLast)
                            bitCnt <= {12'd0, param} - 16'd1;
                        else
                            bitCnt <= bitCnt + 16'd1;
                    end
                    REMAINDER: begin
                        if (bitCnt != 16'd0)
                            bitCnt <= bitCnt - 16'd1;
                    end
                    default: ;
                endcase
            end
            if (sampleDone) begin
                if (!sampleLast) begin
                    sampleCount <= sampleCount + 16'd1;
                end else begin
                    sampleCount <= '0;
                    if (partLast) begin
                        partCount <= '0;
                        frameDone <= 1'b1;
                    end else begin
                        partCount <= partCount + PCW'(1);
                    end
                end
            end
        end
    end

`ifdef RICE_BITCOUNT_EN
    // Held through the frame-done pulse, cleared right after it.
    always_ff @(posedge iClk) begin
        if (iRst)
            oBitCount <= '0;
        else if (frameDone)
            oBitCount <= '0;
        else if (adv)
            oBitCount <= oBitCount + 32'd1;
    end
`endif

    assign bus.oReady     = (state == IDLE);
    assign bus.oValid     = (state != IDLE);
    assign bus.oData      = dataBit;
    assign bus.oFrameDone = frameDone;
endmodule

// File: tb/tb_rice_encode.sv
// Scoreboard bench for rice_encode: expected bits and frame lengths are
// queued at issue time and checked by a negedge monitor.
module tb_rice_encode;
    logic        clk;
    logic        rst;
    logic [15:0] blockSize;
    logic [3:0]  predOrder;
    logic [3:0]  partOrder;
    int          enMode;
    int          total;
    int          bad;
    bit          expQ[$];
    int          frameQ[$];
    int          frameBits;
    bit          prevHold;
    bit          prevData;
    bit          chkZero;
`ifdef RICE_BITCOUNT_EN
    logic [31:0] bitCount;
    int          lastLen;
`endif

    rice_encode_if bus ();

    rice_encode #(.MAX_PART_ORDER(8)) dut (
        .iClk            (clk),
        .iRst            (rst),
        .iBlockSize      (blockSize),
        .iPredictorOrder (predOrder),
        .iPartitionOrder (partOrder),
        .bus             (bus)
`ifdef RICE_BITCOUNT_EN
        ,
        .oBitCount       (bitCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // En driver: 0 = always on, 1 = pattern 1,0,0,1, 2 = off.
    initial begin
        int idx;
        bit [3:0] pat;
        idx = 0;
        pat = 4'b1001;
        bus.iEn = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (enMode == 1) bus.iEn = pat[3 - idx];
            else bus.iEn = (enMode == 0);
            idx = (idx + 1) % 4;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            frameBits = 0;
            prevHold  = 1'b0;
            chkZero   = 1'b0;
        end else begin
            if (prevHold) begin
                check("freeze_valid", int'(bus.oValid), 1);
                check("freeze_data", int'(bus.oData), int'(prevData));
            end
            prevHold = bus.oValid && !bus.iEn;
            prevData = bus.oData;
            if (bus.oValid && bus.iEn) begin
                if (expQ.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    check("stream_bit", int'(bus.oData), int'(expQ.pop_front()));
                end
                frameBits++;
            end
`ifdef RICE_BITCOUNT_EN
            if (chkZero && !bus.oFrameDone)
                check("bitcount_clear", int'(bitCount), 0);
`endif
            chkZero = 1'b0;
            if (bus.oFrameDone) begin
                if (frameQ.size() == 0) begin
                    check("unexpected_framedone", 1, 0);
                end else begin
`ifdef RICE_BITCOUNT_EN
                    lastLen = frameQ[0];
                    check("bitcount_at_done", int'(bitCount), lastLen);
`endif
                    check("frame_len", frameBits, frameQ.pop_front());
                end
                frameBits = 0;
                chkZero   = 1'b1;
            end
        end
    end

    task automatic sendSample(input int msb, input int lsb, input int prm,
                              input string s);
        int waited;
        for (int i = 0; i < s.len(); i++) expQ.push_back(s[i] == "1");
        @(posedge clk);
        #1;
        bus.iValid     = 1'b1;
        bus.iMSB       = 16'(msb);
        bus.iLSB       = 16'(lsb);
        bus.iRiceParam = 4'(prm);
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.oReady) break;
            waited++;
            if (waited > 300) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.iValid = 1'b0;
    endtask

    task automatic waitFrame();
        int waited;
        waited = 0;
        while (frameQ.size() != 0 && waited < 1000) begin
            @(posedge clk);
            waited++;
        end
        if (frameQ.size() != 0) check("frame_timeout", 0, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic frameOne();
        frameQ.push_back(19);
        sendSample(2, 5, 3, "0011001101");
        sendSample(0, 1, 3, "1001");
        sendSample(1, 0, 3, "01000");
    endtask

    initial begin
        int waited;
        total = 0;
        bad = 0;
        enMode = 0;
        rst = 1'b1;
        blockSize = 16'd4;
        predOrder = 4'd1;
        partOrder = 4'd0;
        bus.iValid = 1'b0;
        bus.iMSB = '0;
        bus.iLSB = '0;
        bus.iRiceParam = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(bus.oReady), 1);
        check("rst_valid", int'(bus.oValid), 0);
        check("rst_data", int'(bus.oData), 0);
        check("rst_framedone", int'(bus.oFrameDone), 0);

        frameOne();
        blockSize = 16'd2;
        predOrder = 4'd0;
        partOrder = 4'd0;
        waitFrame();

        frameQ.push_back(9);
        sendSample(3, 0, 0, "00000001");
        sendSample(0, 0, 0, "1");
        blockSize = 16'd8;
        predOrder = 4'd2;
        partOrder = 4'd1;
        waitFrame();

        frameQ.push_back(28);
        sendSample(0, 1, 1, "000111");
        sendSample(1, 0, 1, "010");
        sendSample(0, 3, 2, "0010111");
        sendSample(2, 1, 2, "00101");
        sendSample(0, 0, 2, "100");
        sendSample(1, 2, 2, "0110");
        blockSize = 16'd4;
        predOrder = 4'd1;
        partOrder = 4'd0;
        waitFrame();

        enMode = 1;
        frameOne();
        waitFrame();
        enMode = 0;
        repeat (2) @(posedge clk);

        sendSample(2, 5, 3, "0011001101");
        sendSample(0, 1, 3, "10");
        waited = 0;
        while (expQ.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        if (expQ.size() != 0) check("abort_timeout", 0, 1);
        #1;
        enMode = 2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", int'(bus.oValid), 0);
        check("abort_ready", int'(bus.oReady), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        enMode = 0;
        repeat (2) @(posedge clk);

        frameOne();
        waitFrame();

        check("exp_queue_empty", expQ.size(), 0);
        check("frame_queue_empty", frameQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
